gamecntl_mp: RTL
================

# gamecntl_mp

Parametrised multi-player game control for the pong arcade core. Takes over coin/credit handling, the start sequence, the serve-delay timing and serve-player rotation. Drives the attract, serve and speed-reset strobes consumed by the ball, score and video blocks. Generalises the two-player, single-coin control to N players with a credit counter, a debounced coin input and an explicit state machine.

## Interface
Parameters:
- PLAYERS, 2: number of paddles/servers (2..8)
- CREDIT_W, 4: credit counter width
- MAX_CREDITS, 9: credit saturation value (< 2^CREDIT_W)
- SERVE_COUNTS, 24428694: serve-delay length in CLK_DRV cycles (1.7 s)
- COIN_DEBOUNCE, 16: cycles COIN_SW must be stable before accepted (>= 1)

Ports:
- CLK_DRV  in  1  system clock; all logic on its rising edge
- FPGA_RESET_N  in  1  reset, synchronous, active-low
- COIN_SW  in  1  raw coin switch, active-high
- START_SW  in  1  start button, active-high level
- MISS_N  in  1  ball missed, active-low level
- STOP_G  in  1  game over from score logic, active-high
- PAD  in  PLAYERS  per-player serve buttons, active-high
- SRST, SRST_N  out  1  game reset strobe and complement
- RST_SPEED  out  1  ball-speed reset
- SERVE, SERVE_N  out  1  ball in play and complement
- ATTRACT, ATTRACT_N  out  1  attract mode and complement
- CREDITS  out  CREDIT_W  current credit count
- SERVER  out  PLAYERS  one-hot serving player

## Operation
- FSM states: ATTRACT, START, SERVE_WAIT, SERVE_READY, PLAY.
- Reset (FPGA_RESET_N low at an edge): state ATTRACT, CREDITS=0, SERVER=1 (player 0), delay counter 0, debounce stable=0, edge registers 0. Outputs: ATTRACT=1, SRST=0, RST_SPEED=0, SERVE=0. Reset overrides everything, including mid-serve-delay.
- Coin debounce: counter clears whenever raw COIN_SW differs from stable value. When counter reaches COIN_DEBOUNCE-1 with input still different, stable value takes raw value. A stable 0->1 transition is one coin event.
- Credits: next = min(MAX_CREDITS, CREDITS + coin - take), where take is 1 on an accepted start. Coin plus start in one cycle leaves CREDITS unchanged, including at MAX_CREDITS.
- ATTRACT -> START: START_SW rising edge (current high, previous sample low) and CREDITS >= 1 (pre-cycle value). Otherwise stay in ATTRACT.
- START: exactly one cycle. Asserts SRST. SERVER reset to player 0. Next state is SERVE_WAIT.
- SERVE_WAIT: counter loads 0 on entry and increments each cycle. State lasts exactly SERVE_COUNTS cycles, then goes to SERVE_READY.
- SERVE_READY: waits for a rising edge on PAD[i], where i is the serving player. Edges on other PAD bits are ignored. Then goes to PLAY.
- PLAY: MISS_N low -> rotate SERVER one position (player PLAYERS-1 wraps to 0) and go to SERVE_WAIT.
- STOP_G high in any state except ATTRACT -> ATTRACT. This has priority over MISS_N, PAD and the counter. SERVER is held.
- Ignored inputs: START_SW outside ATTRACT (no credit taken); MISS_N outside PLAY.
- Output decode from the registered state:
  - ATTRACT: high in ATTRACT only.
  - SRST: high in START only.
  - RST_SPEED: high in START and SERVE_WAIT.
  - SERVE: high in PLAY only.
  - Each *_N output is the exact complement.

## Timing
- Inputs are sampled at each rising edge. Edge detection compares with the previous sample.
- A transition triggered at edge n shows on the outputs right after edge n. Outputs are decoded from the state register with no extra register stage.
- Start latency: START_SW rising seen at edge n gives SRST high for cycle n..n+1, and CREDITS decrements at edge n.
- SERVE_WAIT entered at edge m: SERVE_READY at edge m+SERVE_COUNTS.
- Coin: raw rise stable from edge k gives CREDITS increment at edge k+COIN_DEBOUNCE.
- Delay counter width is $clog2(SERVE_COUNTS+1). It never wraps.

## Configuration
- GAMECNTL_FREE_PLAY_EN defined:
  - Start needs no credit.
  - CREDITS is tied to 0 and the coin/debounce logic is removed.
- Not defined: credit operation as described above.

## Test plan
- Reset, then 3 clean coin pulses held 20 cycles each (COIN_DEBOUNCE=16) -> CREDITS=3. A 10-cycle glitch adds nothing.
- CREDITS=1, START_SW pulse -> SRST high exactly 1 cycle, CREDITS=0. SERVE_WAIT lasts SERVE_COUNTS=100 cycles (override) with RST_SPEED high, then SERVE_READY.
- In SERVE_READY with SERVER=1: PAD=2'b10 -> no change. PAD=2'b01 -> SERVE=1. MISS_N low -> SERVER=2'b10, SERVE=0, RST_SPEED=1.
- PLAYERS=3: three misses -> SERVER sequence 001->010->100->001.
- CREDITS=9, coin event and start in the same cycle -> CREDITS stays 9. STOP_G and MISS_N low together in PLAY -> ATTRACT=1, SERVER unchanged.
- FPGA_RESET_N low mid SERVE_WAIT -> next cycle ATTRACT=1, RST_SPEED=0, CREDITS=0. START_SW with 0 credits -> stays ATTRACT (with GAMECNTL_FREE_PLAY_EN defined, enters START).

Source files
------------

// File: rtl/gamecntl_mp.sv
// Multi-player game control for the pong core: coin/credits, start, serve delay and serve rotation.
// Optional GAMECNTL_FREE_PLAY_EN: start without credits, coin logic removed, CREDITS tied to 0.
module gamecntl_mp #(
  parameter int PLAYERS       = 2,
  parameter int CREDIT_W      = 4,
  parameter int MAX_CREDITS   = 9,
  parameter int SERVE_COUNTS  = 24428694,
  parameter int COIN_DEBOUNCE = 16
) (
  input  logic                CLK_DRV,
  input  logic                FPGA_RESET_N,
  input  logic                COIN_SW,
  input  logic                START_SW,
  input  logic                MISS_N,
  input  logic                STOP_G,
  input  logic [PLAYERS-1:0]  PAD,
  output logic                SRST,
  output logic                SRST_N,
  output logic                RST_SPEED,
  output logic                SERVE,
  output logic                SERVE_N,
  output logic                ATTRACT,
  output logic                ATTRACT_N,
  output logic [CREDIT_W-1:0] CREDITS,
  output logic [PLAYERS-1:0]  SERVER
);

  localparam int CNT_W = $clog2(SERVE_COUNTS + 1);
  localparam logic [PLAYERS-1:0] PLAYER0 = {{(PLAYERS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_ATTRACT     = 3'd0,
    ST_START       = 3'd1,
    ST_SERVE_WAIT  = 3'd2,
    ST_SERVE_READY = 3'd3,
    ST_PLAY        = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [PLAYERS-1:0] server_r, server_nxt_s;
  logic [PLAYERS-1:0] pad_prev_r;
  logic [CNT_W-1:0]   dly_cnt_r;
  logic               start_prev_r;
  logic               start_rise_s;
  logic               credit_ok_s;
  logic               take_s;

  assign start_rise_s = START_SW & ~start_prev_r;
  assign take_s       = (state_r == ST_ATTRACT) & start_rise_s & credit_ok_s;

`ifdef GAMECNTL_FREE_PLAY_EN
  logic unused_coin_s;
  assign unused_coin_s = COIN_SW;
  assign credit_ok_s   = 1'b1;
  assign CREDITS       = {CREDIT_W{1'b0}};
`else
  localparam int DB_W = $clog2(COIN_DEBOUNCE + 1);

  logic [DB_W-1:0]     db_cnt_r;
  logic                coin_stable_r;
  logic                coin_prev_r;
  logic                coin_evt_s;
  logic [CREDIT_W-1:0] credits_r, credits_nxt_s;

  assign coin_evt_s  = coin_stable_r & ~coin_prev_r;
  assign credit_ok_s = (credits_r != {CREDIT_W{1'b0}});
  assign CREDITS     = credits_r;

  // Saturating credit update; coin and start in the same cycle cancel.
  always_comb begin
    credits_nxt_s = credits_r;
    if (coin_evt_s && !take_s) begin
      if (credits_r < CREDIT_W'(MAX_CREDITS)) begin
        credits_nxt_s = credits_r + CREDIT_W'(1);
      end else begin
        credits_nxt_s = credits_r;
      end
    end else if (take_s && !coin_evt_s) begin
      credits_nxt_s = credits_r - CREDIT_W'(1);
    end else begin
      credits_nxt_s = credits_r;
    end
  end

  // Coin debounce and credit register.
  always_ff @(posedge CLK_DRV) begin
    if (!FPGA_RESET_N) begin
      db_cnt_r      <= {DB_W{1'b0}};
      coin_stable_r <= 1'b0;
      coin_prev_r   <= 1'b0;
      credits_r     <= {CREDIT_W{1'b0}};
    end else begin
      coin_prev_r <= coin_stable_r;
      credits_r   <= credits_nxt_s;
      if (COIN_SW == coin_stable_r) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else if (db_cnt_r == DB_W'(COIN_DEBOUNCE - 1)) begin
        db_cnt_r      <= {DB_W{1'b0}};
        coin_stable_r <= COIN_SW;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end
  end
`endif

  // Next state and serving player; STOP_G beats every other event outside attract.
  always_comb begin
    state_nxt_s  = state_r;
    server_nxt_s = server_r;
    case (state_r)
      ST_ATTRACT: begin
        if (take_s) state_nxt_s = ST_START;
        else        state_nxt_s = ST_ATTRACT;
      end
      ST_START: begin
        if (STOP_G) begin
          state_nxt_s = ST_ATTRACT;
        end else begin
          state_nxt_s  = ST_SERVE_WAIT;
          server_nxt_s = PLAYER0;
        end
      end
      ST_SERVE_WAIT: begin
        if (STOP_G)                                      state_nxt_s = ST_ATTRACT;
        else if (dly_cnt_r == CNT_W'(SERVE_COUNTS - 1)) state_nxt_s = ST_SERVE_READY;
        else                                             state_nxt_s = ST_SERVE_WAIT;
      end
      ST_SERVE_READY: begin
        if (STOP_G)                                   state_nxt_s = ST_ATTRACT;
        else if (|(PAD & ~pad_prev_r & server_r))     state_nxt_s = ST_PLAY;
        else                                          state_nxt_s = ST_SERVE_READY;
      end
      ST_PLAY: begin
        if (STOP_G) begin
          state_nxt_s = ST_ATTRACT;
        end else if (!MISS_N) begin
          state_nxt_s  = ST_SERVE_WAIT;
          server_nxt_s = {server_r[PLAYERS-2:0], server_r[PLAYERS-1]};
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      default: begin
        state_nxt_s  = ST_ATTRACT;
        server_nxt_s = PLAYER0;
      end
    endcase
  end

  // State, serve-delay counter and edge-detect registers.
  always_ff @(posedge CLK_DRV) begin
    if (!FPGA_RESET_N) begin
      state_r      <= ST_ATTRACT;
      server_r     <= PLAYER0;
      dly_cnt_r    <= {CNT_W{1'b0}};
      start_prev_r <= 1'b0;
      pad_prev_r   <= {PLAYERS{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      server_r     <= server_nxt_s;
      start_prev_r <= START_SW;
      pad_prev_r   <= PAD;
      if (state_r != ST_SERVE_WAIT) begin
        dly_cnt_r <= {CNT_W{1'b0}};
      end else if (dly_cnt_r != CNT_W'(SERVE_COUNTS)) begin
        dly_cnt_r <= dly_cnt_r + CNT_W'(1);
      end else begin
        dly_cnt_r <= dly_cnt_r;
      end
    end
  end

  assign ATTRACT   = (state_r == ST_ATTRACT);
  assign ATTRACT_N = ~ATTRACT;
  assign SRST      = (state_r == ST_START);
  assign SRST_N    = ~SRST;
  assign RST_SPEED = (state_r == ST_START) | (state_r == ST_SERVE_WAIT);
  assign SERVE     = (state_r == ST_PLAY);
  assign SERVE_N   = ~SERVE;
  assign SERVER    = server_r;

endmodule
